// File: rtl/sd_io_arbiter.sv
// Round-robin arbiter sharing the SD-card block-I/O host channel between the
// floppy track buffer (images 0/1) and the SCSI disk (image 2), one sector at a time.
module sd_io_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd16777215
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] fl_lba,
  input  logic [1:0]  fl_rd,
  input  logic [1:0]  fl_wr,
  output logic        fl_busy,
  output logic        fl_done,
  output logic [8:0]  fl_addr,
  output logic        fl_data_en,
  output logic [7:0]  fl_data_in,
  input  logic [7:0]  fl_data_out,
  input  logic [31:0] sc_lba,
  input  logic        sc_rd,
  input  logic        sc_wr,
  output logic        sc_busy,
  output logic        sc_done,
  output logic [8:0]  sc_addr,
  output logic        sc_data_en,
  output logic [7:0]  sc_data_in,
  input  logic [7:0]  sc_data_out,
  output logic [31:0] sd_lba,
  output logic [2:0]  sd_rd,
  output logic [2:0]  sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t      state;
  logic        owner;       // 1 = SCSI owns the channel
  logic        last_owner;
  logic        dir_wr;
  logic        armed;       // sd_ack has been seen low since the request was issued
  logic [23:0] cnt;

  logic       fl_pend;
  logic       sc_pend;
  logic       pick_sc;
  logic [2:0] fl_img_oh;
  logic       fl_dir;

  always_comb begin
    fl_pend = |(fl_rd | fl_wr);
    sc_pend = sc_rd | sc_wr;
    pick_sc = sc_pend && (!fl_pend || !last_owner);
    if (fl_rd[0] | fl_wr[0]) begin
      fl_img_oh = 3'b001;
      fl_dir    = fl_wr[0];
    end else begin
      fl_img_oh = 3'b010;
      fl_dir    = fl_wr[1];
    end
  end

  // Host requests are levels held until sd_ack rises; sd_ack stays high for the
  // whole sector and its fall ends the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      dir_wr     <= 1'b0;
      armed      <= 1'b0;
      cnt        <= 24'd0;
      sd_lba     <= 32'd0;
      sd_rd      <= 3'd0;
      sd_wr      <= 3'd0;
      fl_busy    <= 1'b0;
      sc_busy    <= 1'b0;
      fl_done    <= 1'b0;
      sc_done    <= 1'b0;
      err        <= 1'b0;
    end else begin
      fl_done <= 1'b0;
      sc_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (fl_pend || sc_pend) begin
            owner <= pick_sc;
            cnt   <= 24'd0;
            armed <= 1'b0;
            state <= ISSUE;
            if (pick_sc) begin
              sc_busy <= 1'b1;
              sd_lba  <= sc_lba;
              dir_wr  <= sc_wr;
              sd_rd   <= sc_wr ? 3'b000 : 3'b100;
              sd_wr   <= sc_wr ? 3'b100 : 3'b000;
            end else begin
              fl_busy <= 1'b1;
              sd_lba  <= {21'd0, fl_lba};
              dir_wr  <= fl_dir;
              sd_rd   <= fl_dir ? 3'b000 : fl_img_oh;
              sd_wr   <= fl_dir ? fl_img_oh : 3'b000;
            end
          end
        end
        ISSUE, XFER: begin
          cnt <= cnt + 24'd1;
          if (cnt == TIMEOUT - 24'd1) begin
            sd_rd      <= 3'd0;
            sd_wr      <= 3'd0;
            fl_busy    <= 1'b0;
            sc_busy    <= 1'b0;
            fl_done    <= !owner;
            sc_done    <= owner;
            err        <= 1'b1;
            last_owner <= owner;
            state      <= IDLE;
          end else if (state == ISSUE) begin
            if (sd_ack && armed) begin
              sd_rd <= 3'd0;
              sd_wr <= 3'd0;
              state <= XFER;
            end else if (!sd_ack) begin
              armed <= 1'b1;
            end
          end else if (!sd_ack) begin
            fl_busy <= 1'b0;
            sc_busy <= 1'b0;
            fl_done <= !owner;
            sc_done <= owner;
            state   <= DONE;
          end
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
      endcase
    end
  end

  logic xfer_fl;
  logic xfer_sc;

  // Byte routing is combinational so host data reaches the owner with no latency.
  assign xfer_fl     = (state == XFER) && !owner;
  assign xfer_sc     = (state == XFER) && owner;
  assign fl_addr     = xfer_fl ? sd_buff_addr : 9'd0;
  assign sc_addr     = xfer_sc ? sd_buff_addr : 9'd0;
  assign fl_data_en  = xfer_fl && !dir_wr && sd_buff_wr;
  assign sc_data_en  = xfer_sc && !dir_wr && sd_buff_wr;
  assign fl_data_in  = (xfer_fl && !dir_wr) ? sd_buff_dout : 8'd0;
  assign sc_data_in  = (xfer_sc && !dir_wr) ? sd_buff_dout : 8'd0;
  assign sd_buff_din = ((state == XFER) && dir_wr) ? (owner ? sc_data_out : fl_data_out) : 8'd0;

endmodule
